cnnip_controller: RTL and testbench



---
 rtl/cnnip_pkg.sv | 7 +
 rtl/cnnip_mem_if.sv | 12 +
 rtl/cnnip_mac.sv | 18 +
 rtl/cnnip_controller.sv | 142 ++++++++++++++
 tb/tb_cnnip_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cnnip_pkg.sv
// cnnip_pkg: shared constants and FSM state encoding for the CNN IP convolution controller.
package cnnip_pkg;
   localparam int IMG_DIM = 32;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cnnip_mem_if.sv
// cnnip_mem_if: single-port RAM request/valid bundle between the controller and one memory.
interface cnnip_mem_if;
   import cnnip_pkg::*;
   logic en;
   logic we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic valid;
   modport master (output en, we, addr, din, input dout, valid);
   modport slave (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/cnnip_mac.sv
// cnnip_mac: single multiply-accumulate with wrap-around DATA_W accumulator.
module cnnip_mac
   import cnnip_pkg::*;
(
   input  logic              clk_a,
   input  logic              arstz_aq,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc
);
   // low DATA_W bits of the product are identical for signed and unsigned operands
   always_ff @(posedge clk_a or negedge arstz_aq)
      if (!arstz_aq) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= acc + a * b;
endmodule

// File: rtl/cnnip_controller.sv
// cnnip_controller: walks kernels/pixels/taps, feeds one MAC and writes results to feature memory.
// Build option CNNIP_RELU_EN clamps negative results to zero before the write.
module cnnip_controller
   import cnnip_pkg::*;
(
   input  logic               clk_a,
   input  logic               arstz_aq,
   cnnip_mem_if.master        to_input_mem,
   cnnip_mem_if.master        to_weight_mem,
   cnnip_mem_if.master        to_feature_mem,
   input  logic               CMD_START,
   input  logic [7:0]         MODE_KERNEL_SIZE,
   input  logic [7:0]         MODE_KERNEL_NUMS,
   input  logic [1:0]         MODE_STRIDE,
   input  logic               MODE_PADDING,
   output logic               CMD_DONE,
   output logic               CMD_DONE_VALID
);
   state_t state, nxt;
   logic [7:0] k_q, n_q, o_q, p, kn, o_calc;
   logic [1:0] s_q;
   logic pad_q;
   logic [5:0] oy, ox;
   logic [4:0] ky, kx;
   logic [10:0] iy_raw, ix_raw, iy, ix;
   logic in_rng, in_done, wt_done, in_en, wt_en, tap_ok, tap_adv, ft_go;
   logic kx_last, last_tap, ox_last, oy_last, last_pix, illegal;
   logic [ADDR_W-1:0] in_addr, wt_addr, ft_addr;
   logic [DATA_W-1:0] in_q, wt_q, acc, ft_din;

   assign p = pad_q ? (k_q - 8'd1) >> 1 : '0;
   assign illegal = k_q == 8'd0 || k_q > 8'(IMG_DIM) || n_q == 8'd0 || s_q == 2'd0;
   assign o_calc = (s_q == 2'd0) ? '0 : (8'(IMG_DIM) + (p << 1) - k_q) / {6'b0, s_q} + 8'd1;
   // tap coordinates before padding offset; negative results show up as raw < p
   assign iy_raw = 11'(oy) * 11'(s_q) + 11'(ky);
   assign ix_raw = 11'(ox) * 11'(s_q) + 11'(kx);
   assign iy = iy_raw - 11'(p);
   assign ix = ix_raw - 11'(p);
   assign in_rng = iy_raw >= 11'(p) && ix_raw >= 11'(p) && iy < 11'(IMG_DIM) && ix < 11'(IMG_DIM);
   assign in_addr = ADDR_W'(32'(iy) * IMG_DIM + 32'(ix));
   assign wt_addr = ADDR_W'(32'(kn) * 32'(k_q) * 32'(k_q) + 32'(ky) * 32'(k_q) + 32'(kx));
   assign ft_addr = ADDR_W'(32'(kn) * 32'(o_q) * 32'(o_q) + 32'(oy) * 32'(o_q) + 32'(ox));
   assign in_en = state == READ && in_rng && !in_done;
   assign wt_en = state == READ && in_rng && !wt_done;
   assign tap_ok = !in_rng || ((in_done || to_input_mem.valid) && (wt_done || to_weight_mem.valid));
   assign tap_adv = state == READ && tap_ok;
   assign ft_go = state == WRITE && to_feature_mem.valid;
   assign kx_last = 8'(kx) == k_q - 8'd1;
   assign last_tap = kx_last && 8'(ky) == k_q - 8'd1;
   assign ox_last = 8'(ox) == o_q - 8'd1;
   assign oy_last = 8'(oy) == o_q - 8'd1;
   assign last_pix = ox_last && oy_last && kn == n_q - 8'd1;

`ifdef CNNIP_RELU_EN
   assign ft_din = acc[DATA_W-1] ? '0 : acc;
`else
   assign ft_din = acc;
`endif

   cnnip_mac u_mac (
      .clk_a   (clk_a),
      .arstz_aq(arstz_aq),
      .clr     (state == CHECK || ft_go),
      .en      (tap_adv && in_rng),
      .a       (in_done ? in_q : to_input_mem.dout),
      .b       (wt_done ? wt_q : to_weight_mem.dout),
      .acc     (acc)
   );

   always_ff @(posedge clk_a or negedge arstz_aq)
      if (!arstz_aq) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  nxt = CMD_START ? CHECK : IDLE;
         CHECK: nxt = illegal ? DONE : READ;
         READ:  nxt = (tap_ok && last_tap) ? WRITE : READ;
         WRITE: nxt = to_feature_mem.valid ? (last_pix ? DONE : READ) : WRITE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      to_input_mem.en = in_en;
      to_input_mem.we = 1'b0;
      to_input_mem.addr = in_en ? in_addr : '0;
      to_input_mem.din = '0;
      to_weight_mem.en = wt_en;
      to_weight_mem.we = 1'b0;
      to_weight_mem.addr = wt_en ? wt_addr : '0;
      to_weight_mem.din = '0;
      to_feature_mem.en = state == WRITE;
      to_feature_mem.we = state == WRITE;
      to_feature_mem.addr = state == WRITE ? ft_addr : '0;
      to_feature_mem.din = state == WRITE ? ft_din : '0;
      CMD_DONE_VALID = state == DONE;
   end

   always_ff @(posedge clk_a or negedge arstz_aq)
      if (!arstz_aq) begin
         {k_q, n_q, s_q, pad_q, o_q} <= '0;
         {kn, oy, ox, ky, kx} <= '0;
         {in_done, wt_done, in_q, wt_q} <= '0;
         CMD_DONE <= 1'b0;
      end else begin
         if (state == IDLE && CMD_START) begin
            k_q <= MODE_KERNEL_SIZE;
            n_q <= MODE_KERNEL_NUMS;
            s_q <= MODE_STRIDE;
            pad_q <= MODE_PADDING;
            CMD_DONE <= 1'b0;
         end
         if (state == DONE) CMD_DONE <= 1'b1;
         if (state == CHECK) begin
            o_q <= o_calc;
            {kn, oy, ox, ky, kx} <= '0;
            {in_done, wt_done} <= '0;
         end
         if (in_en && to_input_mem.valid) begin
            in_q <= to_input_mem.dout;
            in_done <= 1'b1;
         end
         if (wt_en && to_weight_mem.valid) begin
            wt_q <= to_weight_mem.dout;
            wt_done <= 1'b1;
         end
         // tap completion overrides the captures above
         if (tap_adv) begin
            {in_done, wt_done} <= '0;
            kx <= kx_last ? '0 : kx + 5'd1;
            if (kx_last) ky <= last_tap ? '0 : ky + 5'd1;
         end
         if (ft_go) begin
            ox <= ox_last ? '0 : ox + 6'd1;
            if (ox_last) oy <= oy_last ? '0 : oy + 6'd1;
            if (ox_last && oy_last) kn <= kn + 8'd1;
         end
      end
endmodule

// File: tb/tb_cnnip_controller.sv
// tb_cnnip_controller: directed checks of reset, basic/padded runs, backpressure, illegal starts and ReLU.
module tb_cnnip_controller;
   import cnnip_pkg::*;
   logic clk_a = 1'b0;
   logic arstz_aq = 1'b0;
   always #5 clk_a = ~clk_a;

   cnnip_mem_if in_if ();
   cnnip_mem_if wt_if ();
   cnnip_mem_if ft_if ();

   logic CMD_START = 1'b0;
   logic [7:0] k_i = '0, n_i = '0;
   logic [1:0] s_i = '0;
   logic p_i = 1'b0;
   logic done, done_v;
   logic in_rdy = 1'b1, wt_rdy = 1'b1, ft_rdy = 1'b1;
   logic [DATA_W-1:0] in_ram [4096];
   logic [DATA_W-1:0] wt_ram [4096];

   assign in_if.valid = in_if.en & in_rdy;
   assign wt_if.valid = wt_if.en & wt_rdy;
   assign ft_if.valid = ft_if.en & ft_rdy;
   assign in_if.dout = in_ram[in_if.addr];
   assign wt_if.dout = wt_ram[wt_if.addr];
   assign ft_if.dout = '0;

   cnnip_controller dut (
      .clk_a           (clk_a),
      .arstz_aq        (arstz_aq),
      .to_input_mem    (in_if),
      .to_weight_mem   (wt_if),
      .to_feature_mem  (ft_if),
      .CMD_START       (CMD_START),
      .MODE_KERNEL_SIZE(k_i),
      .MODE_KERNEL_NUMS(n_i),
      .MODE_STRIDE     (s_i),
      .MODE_PADDING    (p_i),
      .CMD_DONE        (done),
      .CMD_DONE_VALID  (done_v)
   );

   logic [ADDR_W-1:0] wr_a [$];
   logic [DATA_W-1:0] wr_d [$];
   int acc_cnt = 0, dv_cnt = 0;
   always @(posedge clk_a) begin
      if (ft_if.en && ft_if.valid) begin
         wr_a.push_back(ft_if.addr);
         wr_d.push_back(ft_if.din);
      end
      if (in_if.en || wt_if.en || ft_if.en) acc_cnt++;
      if (done_v) dv_cnt++;
   end

   int errors = 0, checks = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int k, input int n, input int s, input int p);
      @(negedge clk_a);
      k_i = 8'(k); n_i = 8'(n); s_i = 2'(s); p_i = 1'(p);
      CMD_START = 1'b1;
      @(negedge clk_a);
      CMD_START = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int i = 0;
      while (!done_v && i < max) begin
         @(negedge clk_a);
         i++;
      end
      chk(tag, done_v, 1);
   endtask

   initial begin
      int base, dv0, ac0, bad, rd, sz;
      logic [ADDR_W-1:0] a0;
      logic [DATA_W-1:0] d0;
      int ill_k [4] = '{0, 33, 3, 3};
      int ill_n [4] = '{1, 1, 0, 1};
      int ill_s [4] = '{1, 1, 1, 0};
      for (int i = 0; i < 4096; i++) begin
         in_ram[i] = 32'd1;
         wt_ram[i] = 32'd1;
      end
      repeat (3) @(negedge clk_a);
      chk("rst_in_en", in_if.en, 0);
      chk("rst_wt_en", wt_if.en, 0);
      chk("rst_ft_en", ft_if.en, 0);
      chk("rst_ft_we", ft_if.we, 0);
      chk("rst_done", done, 0);
      chk("rst_done_v", done_v, 0);
      arstz_aq = 1'b1;

      // basic run K=5 N=1 S=1 no padding, with backpressure and an ignored start
      base = wr_a.size();
      dv0 = dv_cnt;
      start(5, 1, 1, 0);
      chk("lat_check_en", in_if.en, 0);
      @(negedge clk_a);
      chk("lat_read_en", in_if.en, 1);
      chk("tap0_in_addr", in_if.addr, 0);
      chk("tap0_wt_addr", wt_if.addr, 0);
      repeat (5) @(negedge clk_a);
      chk("tap5_in_addr", in_if.addr, 32);
      chk("tap5_wt_addr", wt_if.addr, 5);
      bad = 0;
      while (!(wr_a.size() - base >= 10 && ft_if.en) && bad < 2000) begin
         @(negedge clk_a);
         bad++;
      end
      chk("bp_reach", ft_if.en, 1);
      ft_rdy = 1'b0;
      a0 = ft_if.addr;
      d0 = ft_if.din;
      sz = wr_a.size();
      chk("bp_addr", a0, sz - base);
      bad = 0;
      rd = 0;
      repeat (100) begin
         @(negedge clk_a);
         if (ft_if.addr !== a0 || ft_if.din !== d0 || ft_if.en !== 1'b1) bad++;
         if (in_if.en || wt_if.en) rd++;
      end
      chk("bp_stable", bad, 0);
      chk("bp_no_reads", rd, 0);
      chk("bp_no_writes", wr_a.size(), sz);
      ft_rdy = 1'b1;
      repeat (50) @(negedge clk_a);
      start(0, 1, 1, 0);
      wait_done("basic_timeout", 25000);
      chk("basic_writes", wr_a.size() - base, 784);
      bad = 0;
      for (int i = 0; i < 784; i++)
         if (wr_a[base+i] !== ADDR_W'(i) || wr_d[base+i] !== 32'd25) bad++;
      chk("basic_seq", bad, 0);
      @(negedge clk_a);
      chk("basic_dv_pulses", dv_cnt - dv0, 1);
      chk("basic_done_lvl", done, 1);
      chk("basic_dv_low", done_v, 0);

      // padding and stride: K=3 N=2 S=2 pad -> O=16
      base = wr_a.size();
      start(3, 2, 2, 1);
      chk("pad_done_clr", done, 0);
      wait_done("pad_timeout", 8000);
      chk("pad_writes", wr_a.size() - base, 512);
      chk("pad_a0", wr_a[base], 0);
      chk("pad_d0", wr_d[base], 4);
      chk("pad_a17", wr_a[base+17], 17);
      chk("pad_d17", wr_d[base+17], 9);
      chk("pad_a256", wr_a[base+256], 256);
      chk("pad_d256", wr_d[base+256], 4);
      chk("pad_a511", wr_a[base+511], 511);
      chk("pad_d511", wr_d[base+511], 9);

      // illegal configurations finish in two cycles without memory traffic
      ac0 = acc_cnt;
      for (int i = 0; i < 4; i++) begin
         start(ill_k[i], ill_n[i], ill_s[i], 0);
         chk("ill_dv_early", done_v, 0);
         @(negedge clk_a);
         chk("ill_dv", done_v, 1);
         @(negedge clk_a);
         chk("ill_done", done, 1);
      end
      chk("ill_no_access", acc_cnt, ac0);

      // ReLU behaviour with all weights -1, then asynchronous abort
      for (int i = 0; i < 4096; i++) wt_ram[i] = 32'hFFFF_FFFF;
      start(5, 1, 1, 0);
      bad = 0;
      while (!ft_if.en && bad < 200) begin
         @(negedge clk_a);
         bad++;
      end
`ifdef CNNIP_RELU_EN
      chk("relu_din", ft_if.din, 32'h0);
`else
      chk("relu_din", ft_if.din, 32'hFFFF_FFE7);
`endif
      arstz_aq = 1'b0;
      #1;
      chk("abort_ft_en", ft_if.en, 0);
      chk("abort_ft_din", ft_if.din, 0);
      chk("abort_done", done, 0);
      repeat (2) @(negedge clk_a);
      arstz_aq = 1'b1;
      repeat (3) @(negedge clk_a);
      chk("abort_idle_in_en", in_if.en, 0);
      chk("abort_idle_dv", done_v, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
